huffman_bit_packer: RTL and testbench

- Downstream of the Huffman encoder. Accepts variable-length codewords (code bits plus length) one per handshake and packs them MSB-first into a continuous stream of fixed-width bytes.
- On flush, drains all buffered bits, zero-pads the final partial byte, and marks it with dataLast and the pad count so the decoder can strip the padding.

---
 rtl/huffman_bit_packer.sv | 137 +++++++++++++
 tb/tb_huffman_bit_packer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_bit_packer.sv
// Packs right-aligned variable-length codewords MSB-first into a byte stream.
// On flush the residual bits are zero-padded and tagged with dataLast/padBits.
module huffman_bit_packer #(
    parameter int BYTE_WIDTH   = 8,
    parameter int MAX_CODE_LEN = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int LEN_WIDTH    = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [MAX_CODE_LEN-1:0] codeIn,
    input  logic [LEN_WIDTH-1:0]    codeLen,
    input  logic                    codeValid,
    output logic                    codeReady,
    input  logic                    flush,
    output logic [BYTE_WIDTH-1:0]   dataOut,
    output logic                    dataValid,
    input  logic                    dataReady,
    output logic                    dataLast,
    output logic [2:0]              padBits,
    output logic                    flushDone,
    output logic                    busy
);

    localparam int CW = $clog2(ACC_WIDTH + 1);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    function automatic logic [LEN_WIDTH-1:0] sat_len(input logic [LEN_WIDTH-1:0] len);
        if (len > LEN_WIDTH'(MAX_CODE_LEN))
            return LEN_WIDTH'(MAX_CODE_LEN);
        return len;
    endfunction

    // Masks off bits above len, MSB-aligns the codeword, then slides it behind cnt held bits.
    function automatic logic [ACC_WIDTH-1:0] align_code(input logic [MAX_CODE_LEN-1:0] code,
                                                        input logic [LEN_WIDTH-1:0]    len,
                                                        input logic [CW-1:0]           cnt);
        logic [ACC_WIDTH-1:0] wide;
        wide = {{(ACC_WIDTH-MAX_CODE_LEN){1'b0}}, code};
        wide = wide & ~({ACC_WIDTH{1'b1}} << len);
        wide = wide << (ACC_WIDTH - int'(len));
        return wide >> cnt;
    endfunction

    logic [0:0]           state;
    logic                 flushPending;
    logic [ACC_WIDTH-1:0] acc;
    logic [CW-1:0]        bitCount;

    logic [LEN_WIDTH-1:0] lenSat;
    logic                 take, outFree, extract, isLast;
    logic                 lastXfer, emptyFlush, startFlush;
    logic [ACC_WIDTH-1:0] accShift, accNext;
    logic [CW-1:0]        cntAfter, cntNext;
    logic [CW:0]          cntSum;
    logic [0:0]           stateNext;
    logic                 pendNext;

    // Stage p0: accumulator append/extract and flush control
    always_comb begin
        lenSat  = sat_len(codeLen);
        take    = codeValid && codeReady;
        outFree = !dataValid || dataReady;
        if (state == FLUSH)
            extract = outFree && (bitCount != '0);
        else
            extract = outFree && (bitCount > CW'(BYTE_WIDTH));
        isLast   = extract && (state == FLUSH) && (bitCount <= CW'(BYTE_WIDTH));
        accShift = extract ? (acc << BYTE_WIDTH) : acc;

        cntAfter = bitCount;
        if (isLast)
            cntAfter = '0;
        else if (extract)
            cntAfter = bitCount - CW'(BYTE_WIDTH);

        accNext = accShift;
        cntNext = cntAfter;
        if (take) begin
            accNext = accShift | align_code(codeIn, lenSat, cntAfter);
            cntNext = cntAfter + CW'(lenSat);
        end

        lastXfer   = dataValid && dataReady && dataLast;
        emptyFlush = flush && (state == RUN) && (bitCount == '0) && !dataValid
                     && !(take && (lenSat != '0));
        startFlush = flush && (state == RUN) && !emptyFlush;

        stateNext = state;
        pendNext  = flushPending;
        if (startFlush) begin
            stateNext = FLUSH;
            pendNext  = 1'b1;
        end else if (lastXfer) begin
            stateNext = RUN;
            pendNext  = 1'b0;
        end
        cntSum = {1'b0, cntNext} + (CW+1)'(MAX_CODE_LEN);
    end

    // Stage p1: output byte register
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RUN;
            flushPending <= 1'b0;
            acc          <= '0;
            bitCount     <= '0;
            codeReady    <= 1'b0;
            dataValid    <= 1'b0;
            dataOut      <= '0;
            dataLast     <= 1'b0;
            padBits      <= '0;
            flushDone    <= 1'b0;
        end else begin
            state        <= stateNext;
            flushPending <= pendNext;
            acc          <= accNext;
            bitCount     <= cntNext;
            codeReady    <= (stateNext == RUN) && !pendNext && (cntSum <= (CW+1)'(ACC_WIDTH));
            flushDone    <= lastXfer || emptyFlush;
            if (extract) begin
                dataValid <= 1'b1;
                dataOut   <= acc[ACC_WIDTH-1 -: BYTE_WIDTH];
                dataLast  <= isLast;
                padBits   <= isLast ? 3'(BYTE_WIDTH - int'(bitCount)) : 3'd0;
            end else if (dataValid && dataReady) begin
                dataValid <= 1'b0;
                dataLast  <= 1'b0;
                padBits   <= '0;
            end
        end
    end

    assign busy = (bitCount != '0) || flushPending || dataValid;

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed bench for huffman_bit_packer with a bit-queue reference model
// checked on every cycle, plus literal expectations per scenario.
module tb_huffman_bit_packer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] codeIn = '0;
    logic [4:0]  codeLen = '0;
    logic        codeValid = 1'b0;
    logic        codeReady;
    logic        flush = 1'b0;
    logic [7:0]  dataOut;
    logic        dataValid;
    logic        dataReady = 1'b1;
    logic        dataLast;
    logic [2:0]  padBits;
    logic        flushDone;
    logic        busy;

    always #5 clock = ~clock;

    huffman_bit_packer dut (
        .clock(clock), .reset(reset),
        .codeIn(codeIn), .codeLen(codeLen), .codeValid(codeValid), .codeReady(codeReady),
        .flush(flush),
        .dataOut(dataOut), .dataValid(dataValid), .dataReady(dataReady),
        .dataLast(dataLast), .padBits(padBits), .flushDone(flushDone), .busy(busy)
    );

    typedef struct {
        logic [7:0] d;
        logic       last;
        logic [2:0] pad;
    } xfer_t;

    int    checks = 0;
    int    failures = 0;
    int    accepts = 0;
    bit    bitq[$];
    xfer_t obs[$];
    bit    pending = 0;
    bit    pendAtStart;
    bit    expDone = 0;
    bit    held = 0;
    logic [7:0] heldOut;
    logic       heldLast;
    logic [2:0] heldPad;
    int         mN, mTake, mLen;
    logic [7:0] mByte;
    bit         mLast;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Reference model: a plain bit queue; bytes are consecutive 8-bit slices of it.
    always @(negedge clock) begin
        if (reset) begin
            bitq.delete();
            pending = 0;
            expDone = 0;
            held    = 0;
        end else begin
            pendAtStart = pending;
            chk("flushDone", flushDone, expDone);
            chk("busy", busy, (bitq.size() != 0) || pending);
            if (held) begin
                chk("hold_valid", dataValid, 1);
                chk("hold_data", dataOut, heldOut);
                chk("hold_last", dataLast, heldLast);
                chk("hold_pad", padBits, heldPad);
            end
            expDone = 0;
            if (dataValid && dataReady) begin
                mN = bitq.size();
                if (mN == 0 || (!pendAtStart && mN < 9)) begin
                    fail_now("unexpected_byte");
                end else begin
                    mTake = (mN < 8) ? mN : 8;
                    mByte = '0;
                    for (int i = 0; i < mTake; i++) mByte[7-i] = bitq[i];
                    mLast = pendAtStart && (mN <= 8);
                    chk("xfer_data", dataOut, mByte);
                    chk("xfer_last", dataLast, mLast);
                    chk("xfer_pad", padBits, mLast ? (8 - mN) : 0);
                    for (int i = 0; i < mTake; i++) void'(bitq.pop_front());
                    if (mLast) begin
                        pending = 0;
                        expDone = 1;
                    end
                end
                obs.push_back('{dataOut, dataLast, padBits});
            end
            held     = dataValid && !dataReady;
            heldOut  = dataOut;
            heldLast = dataLast;
            heldPad  = padBits;
            if (codeValid && codeReady) begin
                accepts++;
                mLen = (codeLen > 5'd16) ? 16 : int'(codeLen);
                for (int i = mLen - 1; i >= 0; i--) bitq.push_back(codeIn[i]);
            end
            if (flush && !pendAtStart) begin
                if (bitq.size() == 0) expDone = 1;
                else pending = 1;
            end
        end
    end

    task automatic send(input logic [15:0] c, input logic [4:0] l);
        bit got;
        got = 0;
        @(posedge clock); #1;
        codeIn = c; codeLen = l; codeValid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clock);
            got = codeReady;
            @(posedge clock); #1;
        end
        codeValid = 1'b0;
        if (!got) fail_now("send_timeout");
    endtask

    task automatic pulse_flush();
        @(posedge clock); #1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clock);
            got = flushDone;
        end
        chk(name, got, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_obs(input string name, input int idx, input logic [7:0] d,
                              input logic last, input logic [2:0] pad);
        if (idx < obs.size()) begin
            chk({name, "_data"}, obs[idx].d, d);
            chk({name, "_last"}, obs[idx].last, last);
            chk({name, "_pad"}, obs[idx].pad, pad);
        end else begin
            fail_now({name, "_missing"});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_codeReady", codeReady, 0);
        chk("rst_dataValid", dataValid, 0);
        chk("rst_dataOut", dataOut, 0);
        chk("rst_dataLast", dataLast, 0);
        chk("rst_padBits", padBits, 0);
        chk("rst_flushDone", flushDone, 0);
        chk("rst_busy", busy, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rel_ready_low", codeReady, 0);
        @(negedge clock);
        chk("rel_ready_high", codeReady, 1);

        // Exact byte then flush
        obs.delete();
        send(16'h0001, 5'd1);
        send(16'h0001, 5'd2);
        send(16'h0016, 5'd5);
        idle(4);
        chk("t1_no_early", obs.size(), 0);
        pulse_flush();
        wait_done("t1_done");
        chk("t1_count", obs.size(), 1);
        expect_obs("t1", 0, 8'hB6, 1'b1, 3'd0);

        // Partial byte
        obs.delete();
        send(16'h0ABC, 5'd12);
        idle(3);
        expect_obs("t2a", 0, 8'hAB, 1'b0, 3'd0);
        pulse_flush();
        wait_done("t2_done");
        expect_obs("t2b", 1, 8'hC0, 1'b1, 3'd4);

        // Masking and zero-length codeword
        obs.delete();
        send(16'hFFFF, 5'd3);
        send(16'hFFFF, 5'd0);
        send(16'h0000, 5'd5);
        idle(3);
        chk("t3_no_early", obs.size(), 0);
        pulse_flush();
        wait_done("t3_done");
        chk("t3_count", obs.size(), 1);
        expect_obs("t3", 0, 8'hE0, 1'b1, 3'd0);

        // Over-length codeLen saturates to 16
        obs.delete();
        send(16'h8001, 5'd20);
        idle(3);
        pulse_flush();
        wait_done("t4_done");
        chk("t4_count", obs.size(), 2);
        expect_obs("t4a", 0, 8'h80, 1'b0, 3'd0);
        expect_obs("t4b", 1, 8'h01, 1'b1, 3'd0);

        // Backpressure
        obs.delete();
        @(posedge clock); #1;
        dataReady = 1'b0;
        accepts = 0;
        codeIn = 16'hFFFF; codeLen = 5'd16; codeValid = 1'b1;
        idle(6);
        codeValid = 1'b0;
        @(negedge clock);
        chk("bp_accepts", accepts, 2);
        chk("bp_ready", codeReady, 0);
        chk("bp_valid", dataValid, 1);
        chk("bp_data", dataOut, 8'hFF);
        @(posedge clock); #1;
        dataReady = 1'b1;
        idle(6);
        chk("bp_drained", obs.size(), 3);
        pulse_flush();
        wait_done("bp_done");
        chk("bp_count", obs.size(), 4);
        for (int i = 0; i < 3; i++) expect_obs("bp_mid", i, 8'hFF, 1'b0, 3'd0);
        expect_obs("bp_last", 3, 8'hFF, 1'b1, 3'd0);

        // Empty flush
        obs.delete();
        pulse_flush();
        wait_done("ef_done");
        idle(2);
        chk("ef_no_byte", obs.size(), 0);
        chk("ef_ready", codeReady, 1);
        chk("ef_busy", busy, 0);

        // Reset mid-stream
        @(posedge clock); #1;
        dataReady = 1'b0;
        send(16'h05A5, 5'd12);
        idle(2);
        @(negedge clock);
        chk("mr_held", dataValid, 1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        chk("mr_valid", dataValid, 0);
        chk("mr_busy", busy, 0);
        dataReady = 1'b1;
        obs.delete();
        pulse_flush();
        wait_done("mr_done");
        idle(2);
        chk("mr_no_byte", obs.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
